camera_config_seq: RTL

//  Parametrised camera register-write sequencer; next generation of the fixed 25-entry camera setup block.
//  - Walks a runtime-supplied table of N_REGS {addr,data} pairs.
//  - Issues each pair as one write to the I2C master (I2C_Controller GO/END/ACK handshake).
//  - Adds bounded retry, transaction timeout, inter-write gap, restart-on-demand and error reporting.
//  - Sits between the Avalon-visible camera register file and the I2C master.

---
 rtl/camera_config_pkg.sv | 47 ++++
 rtl/camera_config_timer.sv | 37 +++
 rtl/camera_config_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_config_pkg.sv
// ---------------------------------------------------------------------------
// camera_config_pkg
// Shared types and helpers for the camera register-write sequencer.
//   seq_state_t   : sequencer FSM states (VREAD/VWAIT only reached when the
//                   read-back option CAMERA_CFG_VERIFY_EN is compiled in)
//   I2C_WRITE/READ: transfer direction driven on i2c_rd
//   idx_width     : width of the table index / err_index
//   timer_width   : width of the shared timeout/gap down-counter
//   count_width   : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package camera_config_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      GO,
      WAIT,
      RETRY,
      DRAIN,
      GAP,
      DONE,
      ERROR,
      VREAD,
      VWAIT
   } seq_state_t;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   // A one-entry table still needs a 1-bit index so err_index has a width.
   function automatic int idx_width(input int n_regs);
      return (n_regs <= 1) ? 1 : $clog2(n_regs);
   endfunction

   function automatic int count_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // One counter serves both the transaction timeout and the inter-write gap,
   // so it is sized for whichever of the two is larger.
   function automatic int timer_width(input int timeout_cyc, input int gap_cyc);
      int span;
      span = (timeout_cyc > gap_cyc) ? timeout_cyc : gap_cyc;
      return count_width(span);
   endfunction

endpackage

// File: rtl/camera_config_timer.sv
// ---------------------------------------------------------------------------
// camera_config_timer
// Loadable saturating down-counter with a zero flag.
//   clock, reset : system clock, synchronous active-high reset (count -> 0)
//   load         : load load_val this cycle (wins over dec)
//   load_val     : value to load
//   dec          : decrement by one, sticking at zero
//   zero         : count is zero
// ---------------------------------------------------------------------------
module camera_config_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load has priority so the sequencer can restart the count on the same
   // cycle it stops using the previous one; decrement saturates at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/camera_config_seq.sv
// ---------------------------------------------------------------------------
// camera_config_seq
// Walks a table of N_REGS {addr,data} pairs and issues each as one write to
// the I2C master using its GO/END/ACK handshake, with bounded retry,
// transaction timeout, inter-write gap, restart on start and error report.
//
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   start          : pulse, (re)run from entry 0; ignored while busy
//   tbl_addr       : flattened sub-addresses, entry i at [i*ADDR_W +: ADDR_W]
//   tbl_data       : flattened data, entry i at [i*DATA_W +: DATA_W]
//   busy           : sequence in progress
//   out_ready      : all entries written and acknowledged
//   error          : sequence aborted, err_index entry exhausted its retries
//   err_index      : failing entry
//   i2c_go         : transfer request to the I2C master
//   i2c_data       : {SLAVE_ADDR, addr, data}
//   i2c_end        : transfer finished (level, asynchronous to us)
//   i2c_ack        : 1 = slave NACKed
//
// Optional feature, macro CAMERA_CFG_VERIFY_EN: each acknowledged write is
// read back (extra ports i2c_rd out, i2c_rdata in, verify_fail out); a
// read-back mismatch is treated as a failed attempt, and verify_fail marks an
// abort whose final failed attempt was such a mismatch.
// ---------------------------------------------------------------------------
module camera_config_seq
   import camera_config_pkg::*;
#(
   parameter int         N_REGS      = 25,
   parameter int         ADDR_W      = 8,
   parameter int         DATA_W      = 16,
   parameter logic [7:0] SLAVE_ADDR  = 8'hBA,
   parameter int         MAX_RETRY   = 3,
   parameter int         TIMEOUT_CYC = 200000,
   parameter int         GAP_CYC     = 64,
   parameter bit         AUTO_START  = 1'b1,
   localparam int        IDX_W       = idx_width(N_REGS)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [N_REGS*ADDR_W-1:0]   tbl_addr,
   input  logic [N_REGS*DATA_W-1:0]   tbl_data,
   output logic                       busy,
   output logic                       out_ready,
   output logic                       error,
   output logic [IDX_W-1:0]           err_index,
   output logic                       i2c_go,
   output logic [8+ADDR_W+DATA_W-1:0] i2c_data,
   input  logic                       i2c_end,
   input  logic                       i2c_ack
`ifdef CAMERA_CFG_VERIFY_EN
   ,
   output logic                       i2c_rd,
   input  logic [DATA_W-1:0]          i2c_rdata,
   output logic                       verify_fail
`endif
);

   localparam int              TMR_W       = timer_width(TIMEOUT_CYC, GAP_CYC);
   localparam int              RTY_W       = count_width(MAX_RETRY);
   // The timer is loaded on the edge that raises go (or enters GAP) and the
   // zero flag is acted on at the edge that ends the wait, so loading N-1
   // gives exactly N cycles of go-high / gap.
   localparam logic [TMR_W-1:0] TO_LOAD     = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [TMR_W-1:0] GAP_LOAD    = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REGS - 1);
   localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry;
   logic             auto_pend;
   logic [1:0]       end_sync;
   logic [1:0]       ack_sync;
   logic             end_s;
   logic             ack_s;
   logic             enter_gap;
   logic             tmr_load;
   logic             tmr_dec;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;
`ifdef CAMERA_CFG_VERIFY_EN
   logic             mismatch;
`endif

   // END and ACK come from the I2C master's domain; two flops each keep them
   // aligned with one another so a NACK is seen together with its END.
   always_ff @(posedge clock) begin
      if (reset) begin
         end_sync <= '0;
         ack_sync <= '0;
      end else begin
         end_sync <= {end_sync[0], i2c_end};
         ack_sync <= {ack_sync[0], i2c_ack};
      end
   end

   assign end_s = end_sync[1];
   assign ack_s = ack_sync[1];

   // Timer control: the timeout count starts when go is raised, the gap count
   // starts on the cycle a transfer is accepted as good.
   always_comb begin
      enter_gap = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
`ifdef CAMERA_CFG_VERIFY_EN
      enter_gap = (state == VWAIT) && end_s && !ack_s &&
                  (i2c_rdata == i2c_data[DATA_W-1:0]);
      tmr_load  = (state == GO) || ((state == VREAD) && !end_s) || enter_gap;
      tmr_dec   = (state == WAIT) || (state == VWAIT) || (state == GAP);
`else
      enter_gap = (state == WAIT) && end_s && !ack_s;
      tmr_load  = (state == GO) || enter_gap;
      tmr_dec   = (state == WAIT) || (state == GAP);
`endif
      tmr_val   = enter_gap ? GAP_LOAD : TO_LOAD;
   end

   camera_config_timer #(
      .WIDTH    (TMR_W)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Sequencer FSM with registered outputs. A synchronous reset drops go on
   // the reset edge even mid-transfer. auto_pend makes IDLE leave on the
   // first cycle after reset when AUTO_START is set.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         retry     <= '0;
         auto_pend <= AUTO_START;
         busy      <= 1'b0;
         out_ready <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
         i2c_go    <= 1'b0;
         i2c_data  <= '0;
`ifdef CAMERA_CFG_VERIFY_EN
         i2c_rd      <= I2C_WRITE;
         verify_fail <= 1'b0;
         mismatch    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start || auto_pend) begin
                  auto_pend <= 1'b0;
                  idx       <= '0;
                  retry     <= '0;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               i2c_data <= {SLAVE_ADDR,
                            tbl_addr[idx*ADDR_W +: ADDR_W],
                            tbl_data[idx*DATA_W +: DATA_W]};
               state    <= GO;
            end
            GO: begin
               i2c_go <= 1'b1;
`ifdef CAMERA_CFG_VERIFY_EN
               i2c_rd <= I2C_WRITE;
`endif
               state  <= WAIT;
            end
            WAIT: begin
               if (end_s) begin
                  i2c_go <= 1'b0;
                  if (!ack_s) begin
`ifdef CAMERA_CFG_VERIFY_EN
                     state <= VREAD;
`else
                     state <= GAP;
`endif
                  end else begin
                     state <= RETRY;
                  end
`ifdef CAMERA_CFG_VERIFY_EN
                  mismatch <= 1'b0;
`endif
               end else if (tmr_zero) begin
                  i2c_go <= 1'b0;
                  state  <= RETRY;
`ifdef CAMERA_CFG_VERIFY_EN
                  mismatch <= 1'b0;
`endif
               end
            end
            RETRY: begin
               if (retry < RETRY_LIMIT) begin
                  retry <= retry + RTY_W'(1);
                  state <= DRAIN;
               end else begin
                  error     <= 1'b1;
                  err_index <= idx;
                  busy      <= 1'b0;
`ifdef CAMERA_CFG_VERIFY_EN
                  verify_fail <= mismatch;
`endif
                  state     <= ERROR;
               end
            end
            DRAIN: begin
               if (!end_s) begin
                  state <= GO;
               end
            end
            GAP: begin
               if (!end_s && tmr_zero) begin
                  if (idx == LAST_IDX) begin
                     out_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     retry <= '0;
                     state <= LOAD;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  out_ready <= 1'b0;
                  idx       <= '0;
                  retry     <= '0;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            ERROR: begin
               if (start) begin
                  error <= 1'b0;
`ifdef CAMERA_CFG_VERIFY_EN
                  verify_fail <= 1'b0;
`endif
                  idx   <= '0;
                  retry <= '0;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
`ifdef CAMERA_CFG_VERIFY_EN
            VREAD: begin
               if (!end_s) begin
                  i2c_go <= 1'b1;
                  i2c_rd <= I2C_READ;
                  state  <= VWAIT;
               end
            end
            VWAIT: begin
               if (end_s) begin
                  i2c_go <= 1'b0;
                  i2c_rd <= I2C_WRITE;
                  if (enter_gap) begin
                     state <= GAP;
                  end else begin
                     mismatch <= !ack_s;
                     state    <= RETRY;
                  end
               end else if (tmr_zero) begin
                  i2c_go   <= 1'b0;
                  i2c_rd   <= I2C_WRITE;
                  mismatch <= 1'b0;
                  state    <= RETRY;
               end
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
